rv_instr_encoder: RTL
=====================

Name: rv_instr_encoder

Overview:
- Sequential RV32I instruction encoder, the inverse of the UC opcode decoder: takes an instruction class plus fields and builds the 32-bit instruction word.
- Writes each word into instruction memory at an auto-incrementing word address.
- Used to load programs and to generate stimulus that drives UC/datapath from the fetch side.
- Per instruction: valid/ready field handshake in, held-until-acknowledged memory write out.

Parameters:
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first write address after reset or clr

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  sync: restart address at BASE_ADDR, clear err/wrap (honoured in IDLE only)
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept bundle
fmt  in  3  0=R 1=I_LOAD 2=I_ALU 3=I_JALR 4=S 5=B 6=U(lui) 7=J(jal)
funct3  in  3  funct3 field
funct7  in  7  funct7 field (R; I_ALU shifts)
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
imm  in  32  immediate as signed byte value (U: full upper value)
wr_en  out  1  memory write request
wr_addr  out  ADDR_W  word address
wr_data  out  32  encoded instruction
wr_ack  in  1  memory accepted write this cycle
err  out  1  sticky: bundle dropped, immediate out of range
wrap  out  1  sticky: address wrapped past all-ones

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=0 during reset, wr_en=0, wr_data=0, wr_addr=BASE_ADDR, err=0, wrap=0. Applies immediately, including mid-WRITE: wr_en drops with no ack required.
- FSM IDLE -> ENCODE -> WRITE -> IDLE.
  - IDLE: in_ready=1. On in_valid, register all fields and go to ENCODE.
  - ENCODE: in_ready=0. Build word and range-check immediate.
    - Check fails: err<=1, return to IDLE, no write, address unchanged.
    - Check passes: load wr_data, go to WRITE.
  - WRITE: wr_en=1. wr_addr/wr_data held stable until the cycle wr_ack=1.
    - On that cycle: wr_addr<=wr_addr+1 (modulo 2^ADDR_W; all-ones->0 sets wrap), go to IDLE.
    - Next cycle: wr_en=0.
- Latency: handshake at edge N; wr_en high from N+2. Minimum 3 cycles per instruction with wr_ack tied high.
- Opcodes: R 0110011, I_LOAD 0000011, I_ALU 0010011, I_JALR 1100111, S 0100011, B 1100011, U 0110111, J 1101111.
- Field placement follows the RV32I base formats. Unused fields are ignored and forced to zero in the word (e.g. rs1/rs2 for U/J).
- Immediate rules:
  - I/S: signed −2048..2047.
  - I_ALU with funct3 001/101: word[31:25]=funct7, word[24:20]=imm[4:0]; require 0<=imm<=31.
  - B: signed 13-bit, −4096..4094, imm[0]=0.
  - J: signed 21-bit, imm[0]=0.
  - U: imm[11:0]=0; word[31:12]=imm[31:12].
- clr in IDLE: wr_addr<=BASE_ADDR, err<=0, wrap<=0. If clr and in_valid occur in the same cycle, the bundle is accepted and written at BASE_ADDR. clr outside IDLE is ignored.
- wr_ack outside WRITE is ignored. in_valid while in_ready=0 is not accepted; the source must hold it.

Decomposition:
- Shared package: fmt encodings (FMT_R..FMT_J) and the eight opcode constants. UC also uses these, so both ends share one source.
- One sub-module: rv_imm_pack. Purely combinational: fmt, funct3, funct7, imm -> packed immediate bits and range_ok. The FSM, address counter and flags stay in the top.

Test Plan:
- R add x3,x1,x2 (fmt0, f3=0, f7=0) -> wr_data=0x002081B3 at addr 0; wr_en rises 2 cycles after handshake.
- addi x1,x0,5 then sw x2,8(x1) -> 0x00500093 at addr 0, 0x0020A423 at addr 1.
- beq x1,x2,imm=−4 -> 0xFE208EE3; lui x5,imm=0x12345000 -> 0x123452B7; jal x1,imm=2048 -> 0x001000EF.
- addi imm=2048, beq imm=3, lui imm=0x12345001 -> err=1, no wr_en, address unchanged; clr -> err=0.
- wr_ack low 3 cycles in WRITE -> wr_en/addr/data stable, in_ready=0; single ack -> addr+1, IDLE next cycle.
- ADDR_W=2, five writes -> fifth written at addr 0, wrap=1. rst_n low during WRITE -> wr_en=0 at once, addr=0.

Source files
------------

// File: rtl/rv_instr_encoder_pkg.sv
// Shared RV32I format and opcode constants.
// Used by the instruction encoder and by the UC opcode decoder.
package rv_instr_encoder_pkg;

    localparam logic [2:0] FMT_R      = 3'd0;
    localparam logic [2:0] FMT_I_LOAD = 3'd1;
    localparam logic [2:0] FMT_I_ALU  = 3'd2;
    localparam logic [2:0] FMT_I_JALR = 3'd3;
    localparam logic [2:0] FMT_S      = 3'd4;
    localparam logic [2:0] FMT_B      = 3'd5;
    localparam logic [2:0] FMT_U      = 3'd6;
    localparam logic [2:0] FMT_J      = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_I_JALR = 7'b1100111;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_U      = 7'b0110111;
    localparam logic [6:0] OP_J      = 7'b1101111;

    function automatic logic [6:0] fmt_opcode(input logic [2:0] f);
        logic [6:0] op;
        case (f)
            FMT_R:      op = OP_R;
            FMT_I_LOAD: op = OP_I_LOAD;
            FMT_I_ALU:  op = OP_I_ALU;
            FMT_I_JALR: op = OP_I_JALR;
            FMT_S:      op = OP_S;
            FMT_B:      op = OP_B;
            FMT_U:      op = OP_U;
            default:    op = OP_J;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Combinational immediate packer: places the immediate in its RV32I bit
// positions and range-checks it. Ports: fmt, funct3, funct7, imm in;
// imm_bits (word with only immediate/shift bits set), range_ok out.
module rv_imm_pack
    import rv_instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_ok
);

    logic fits12;
    logic fits13;
    logic fits21;
    logic is_shift;

    // Signed fit: every bit above the sign bit equals the sign bit.
    assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        imm_bits = '0;
        range_ok = 1'b1;
        case (fmt)
            FMT_I_LOAD, FMT_I_JALR: begin
                imm_bits = {imm[11:0], 20'b0};
                range_ok = fits12;
            end
            FMT_I_ALU: begin
                if (is_shift) begin
                    // Shift amount sits where imm[4:0] would, funct7 above it.
                    imm_bits = {funct7, imm[4:0], 20'b0};
                    range_ok = (imm[31:5] == '0);
                end else begin
                    imm_bits = {imm[11:0], 20'b0};
                    range_ok = fits12;
                end
            end
            FMT_S: begin
                imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                range_ok = fits12;
            end
            FMT_B: begin
                imm_bits = {imm[12], imm[10:5], 13'b0,
                            imm[4:1], imm[11], 7'b0};
                range_ok = fits13 && !imm[0];
            end
            FMT_U: begin
                imm_bits = {imm[31:12], 12'b0};
                range_ok = (imm[11:0] == '0);
            end
            FMT_J: begin
                imm_bits = {imm[20], imm[10:1], imm[11],
                            imm[19:12], 12'b0};
                range_ok = fits21 && !imm[0];
            end
            default: begin
                imm_bits = '0;
                range_ok = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// Sequential RV32I encoder: accepts a field bundle, builds the word and
// writes it to instruction memory at an auto-incrementing word address.
// Ports: clk, rst_n, clr; in_valid/in_ready + fields in; wr_en/wr_addr/
// wr_data/wr_ack memory write; sticky err (bad immediate) and wrap.
module rv_instr_encoder
    import rv_instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ack,
    output logic              err,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ENCODE = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;

    logic [1:0]  state;
    logic [2:0]  fmt_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [4:0]  rd_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [31:0] imm_q;
    logic [31:0] imm_bits;
    logic        range_ok;
    logic [31:0] word;

    // Held low while reset is asserted even though state reads IDLE.
    assign in_ready = rst_n && (state == IDLE);

    rv_imm_pack u_imm_pack (
        .fmt      (fmt_q),
        .funct3   (funct3_q),
        .funct7   (funct7_q),
        .imm      (imm_q),
        .imm_bits (imm_bits),
        .range_ok (range_ok)
    );

    // Register fields not used by a format stay zero in the word.
    always_comb begin
        word = imm_bits | {25'b0, fmt_opcode(fmt_q)};
        case (fmt_q)
            FMT_R:
                word = word | {funct7_q, rs2_q, rs1_q,
                               funct3_q, rd_q, 7'b0};
            FMT_I_LOAD, FMT_I_ALU, FMT_I_JALR:
                word = word | {12'b0, rs1_q, funct3_q, rd_q, 7'b0};
            FMT_S, FMT_B:
                word = word | {7'b0, rs2_q, rs1_q, funct3_q, 12'b0};
            default:
                word = word | {20'b0, rd_q, 7'b0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fmt_q    <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            wr_addr  <= BASE;
            err      <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        wr_addr <= BASE;
                        err     <= 1'b0;
                        wrap    <= 1'b0;
                    end
                    if (in_valid) begin
                        fmt_q    <= fmt;
                        funct3_q <= funct3;
                        funct7_q <= funct7;
                        rd_q     <= rd;
                        rs1_q    <= rs1;
                        rs2_q    <= rs2;
                        imm_q    <= imm;
                        state    <= ENCODE;
                    end
                end
                ENCODE: begin
                    if (range_ok) begin
                        wr_data <= word;
                        wr_en   <= 1'b1;
                        state   <= WRITE;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (wr_ack) begin
                        wr_en   <= 1'b0;
                        wr_addr <= wr_addr + ADDR_W'(1);
                        if (&wr_addr) wrap <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
